// File: rtl/spi_read_seq_if.sv
// Byte-stream link between spi_read_seq and a bit-bang spi_master.
//   tx_data  : byte offered to the master (sequencer drives)
//   tx_empty : no byte offered; master closes the frame (sequencer drives)
//   tx_get   : master took tx_data this cycle (master drives)
//   rx_data  : byte shifted in by the master (master drives)
//   rx_put   : rx_data valid this cycle (master drives)
// Modports: master = spi_master side, slave = sequencer side.
interface spi_read_seq_if;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_get;
    logic [7:0] rx_data;
    logic       rx_put;

    modport master (
        input  tx_data, tx_empty,
        output tx_get, rx_data, rx_put
    );

    modport slave (
        output tx_data, tx_empty,
        input  tx_get, rx_data, rx_put
    );
endinterface

// File: rtl/spi_read_seq.sv
// Serial-flash read sequencer. Feeds CMD, the address (MSB byte first) and
// len dummy bytes to the spi_master byte source, then drops the header echoes
// coming back on the byte sink and forwards the len payload bytes.
// Ports:
//   clock, reset_n  : rising-edge clock, asynchronous active-low reset
//   start           : read request, honoured only in IDLE
//   addr, len       : read address / payload byte count, captured on start
//   busy            : frame in progress
//   done            : one-cycle pulse with the last payload byte (or last echo)
//   spi             : byte-stream link to the spi_master (slave modport)
//   data, valid     : payload byte and its one-cycle strobe
module spi_read_seq #(
    parameter int          ADDR_BYTES = 3,
    parameter int          LEN_W      = 16,
    parameter logic [7:0]  CMD        = 8'h03,
    parameter logic [7:0]  DUMMY      = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    spi_read_seq_if.slave           spi,
    output logic [7:0]              data,
    output logic                    valid
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int CW = LEN_W + 1;
    localparam logic [CW-1:0] HDR      = CW'(1 + ADDR_BYTES);
    localparam logic [CW-1:0] LAST_ADR = CW'(ADDR_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_PAYLOAD,
        S_WAIT
    } state_e;

    state_e          state;
    logic [AW-1:0]   addr_sh;   // address shifted left as bytes go out
    logic [LEN_W-1:0] len_reg;
    logic [CW-1:0]   tx_cnt;    // bytes taken by the master so far
    logic [CW-1:0]   rx_cnt;    // bytes pushed back by the master so far

    logic [CW-1:0]   total;
    logic [CW-1:0]   tx_cnt_inc;
    logic [CW-1:0]   rx_cnt_inc;

    assign total      = HDR + {1'b0, len_reg};
    assign tx_cnt_inc = tx_cnt + 1'b1;
    assign rx_cnt_inc = rx_cnt + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            addr_sh      <= '0;
            len_reg      <= '0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            valid        <= 1'b0;
            data         <= 8'h00;
            spi.tx_data  <= 8'h00;
            spi.tx_empty <= 1'b1;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;

            // Tx side: the offered byte only moves after the master takes it.
            // A get while nothing is offered (IDLE/WAIT) is simply ignored.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_sh      <= addr;
                        len_reg      <= len;
                        tx_cnt       <= '0;
                        rx_cnt       <= '0;
                        busy         <= 1'b1;
                        spi.tx_empty <= 1'b0;
                        spi.tx_data  <= CMD;
                        state        <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (spi.tx_get) begin
                        tx_cnt      <= tx_cnt_inc;
                        spi.tx_data <= addr_sh[AW-1 -: 8];
                        addr_sh     <= addr_sh << 8;
                        state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (spi.tx_get) begin
                        tx_cnt <= tx_cnt_inc;
                        // tx_cnt already includes CMD, so it equals
                        // ADDR_BYTES when the final address byte goes.
                        if (tx_cnt == LAST_ADR) begin
                            if (len_reg != '0) begin
                                spi.tx_data <= DUMMY;
                                state       <= S_PAYLOAD;
                            end else begin
                                spi.tx_empty <= 1'b1;
                                state        <= S_WAIT;
                            end
                        end else begin
                            spi.tx_data <= addr_sh[AW-1 -: 8];
                            addr_sh     <= addr_sh << 8;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (spi.tx_get) begin
                        tx_cnt <= tx_cnt_inc;
                        if (tx_cnt_inc == total) begin
                            spi.tx_empty <= 1'b1;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Leave one cycle after the final echo, so the done
                    // cycle itself still refuses a new start.
                    if (rx_cnt == total) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Rx side runs independently of the tx state while busy.
            if (busy && spi.rx_put) begin
                rx_cnt <= rx_cnt_inc;
                if (rx_cnt >= HDR) begin
                    valid <= 1'b1;
                    data  <= spi.rx_data;
                end
                if (rx_cnt_inc == total) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule
